// File: rtl/pcpi_bridge_pkg.sv
// Shared types and sizing helpers for the nibble-serial PCPI bridge
// (inbound instruction receiver and outbound result transmitter).
package pcpi_bridge_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    PRESENT = 2'b01,
    RELEASE = 2'b10
  } tx_state_e;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_NIB_W  = 4;
  localparam int NIBBLES    = DEF_DATA_W / DEF_NIB_W;
  localparam int CNT_W      = $clog2(NIBBLES);

  function automatic int nibbles_of(input int data_w, input int nib_w);
    return data_w / nib_w;
  endfunction

  // A single-nibble word still needs a 1-bit counter to stay a legal vector.
  function automatic int cnt_w_of(input int data_w, input int nib_w);
    return (data_w / nib_w > 1) ? $clog2(data_w / nib_w) : 1;
  endfunction

endpackage

// File: rtl/pcpi_result_hold.sv
// One-entry holding register for a result that arrives while a word is
// still streaming; flags a drop when a load finds it already occupied.
module pcpi_result_hold
  import pcpi_bridge_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              take,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] data,
  output logic              full,
  output logic              drop
);

  logic [DATA_W-1:0] data_reg;
  logic              full_reg;

  // A take frees the slot in the same cycle, so a simultaneous load refills it.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_reg <= '0;
      full_reg <= 1'b0;
    end else if (load && (!full_reg || take)) begin
      data_reg <= din;
      full_reg <= 1'b1;
    end else if (take) begin
      full_reg <= 1'b0;
    end
  end

  assign data = data_reg;
  assign full = full_reg;
  assign drop = load & full_reg & ~take;

endmodule

// File: rtl/pcpi_result_nibble_tx.sv
// Captures a PCPI coprocessor result and streams it to the host one nibble
// per four-phase tx_ack handshake, least-significant nibble first.
module pcpi_result_nibble_tx
  import pcpi_bridge_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int NIB_W      = DEF_NIB_W,
  parameter int REQUIRE_WR = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pcpi_ready,
  input  logic              pcpi_wr,
  input  logic [DATA_W-1:0] pcpi_rd,
  input  logic              tx_ack,
  input  logic              clr_overrun,
  output logic [NIB_W-1:0]  tx_nibble,
  output logic              tx_valid,
  output logic              tx_last,
  output logic              busy,
  output logic              overrun
);

  localparam int NIB_CNT  = nibbles_of(DATA_W, NIB_W);
  localparam int CNT_BITS = cnt_w_of(DATA_W, NIB_W);
  localparam logic [CNT_BITS-1:0] CNT_LAST = CNT_BITS'(NIB_CNT - 1);

  tx_state_e           state_reg, state_next;
  logic [DATA_W-1:0]   sh_reg, sh_next;
  logic [CNT_BITS-1:0] cnt_reg, cnt_next;
  logic                done_reg, done_next;
  logic                overrun_reg;

  logic                wr_ok;
  logic                cap;
  logic                at_last;
  logic                hold_load;
  logic                hold_take;
  logic                hold_full;
  logic                hold_drop;
  logic [DATA_W-1:0]   hold_data;

  assign wr_ok = (REQUIRE_WR == 0) ? 1'b1 : pcpi_wr;
  assign cap   = pcpi_ready & wr_ok;

  // Anything that cannot go straight into the shifter goes to the hold slot,
  // including a capture in the same IDLE cycle that drains the slot.
  assign hold_load = cap & ((state_reg != IDLE) | hold_full);

  pcpi_result_hold #(
    .DATA_W(DATA_W)
  ) u_hold (
    .clk  (clk),
    .rst  (rst),
    .load (hold_load),
    .take (hold_take),
    .din  (pcpi_rd),
    .data (hold_data),
    .full (hold_full),
    .drop (hold_drop)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      sh_reg    <= '0;
      cnt_reg   <= '0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      sh_reg    <= sh_next;
      cnt_reg   <= cnt_next;
      done_reg  <= done_next;
    end
  end

  // A drop in the same cycle as a clear must still leave the flag set.
  always_ff @(posedge clk) begin
    if (rst) begin
      overrun_reg <= 1'b0;
    end else if (hold_drop) begin
      overrun_reg <= 1'b1;
    end else if (clr_overrun) begin
      overrun_reg <= 1'b0;
    end
  end

  assign at_last = (cnt_reg == CNT_LAST);

  always_comb begin
    state_next = state_reg;
    sh_next    = sh_reg;
    cnt_next   = cnt_reg;
    done_next  = done_reg;
    hold_take  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (hold_full) begin
          sh_next    = hold_data;
          cnt_next   = '0;
          hold_take  = 1'b1;
          state_next = PRESENT;
        end else if (cap) begin
          sh_next    = pcpi_rd;
          cnt_next   = '0;
          state_next = PRESENT;
        end
      end
      PRESENT: begin
        if (tx_ack) begin
          sh_next    = sh_reg >> NIB_W;
          cnt_next   = at_last ? '0 : cnt_reg + CNT_BITS'(1);
          done_next  = at_last;
          state_next = RELEASE;
        end
      end
      RELEASE: begin
        // Waiting for ack to drop is what keeps a held ack from double-advancing.
        if (!tx_ack) begin
          if (done_reg) begin
            done_next  = 1'b0;
            state_next = IDLE;
          end else begin
            state_next = PRESENT;
          end
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign tx_valid  = (state_reg == PRESENT);
  assign tx_last   = tx_valid & at_last;
  assign tx_nibble = sh_reg[NIB_W-1:0];
  assign busy      = (state_reg != IDLE) | hold_full;
  assign overrun   = overrun_reg;

endmodule
